// File: rtl/dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer
//
// Initiator-side controller for a DSP48A1-style multiply/accumulate slice.
// Accepts a stream of operand pairs and drives the slice so that it computes
// one dot product sum(a_i * b_i) per vector. It presents each completed
// result with its own valid/ready handshake.
//
// The slice is expected to be configured with one A/B register stage, an M
// register, a P register and an OPMODE register. Operands reach the slice M
// register MLAT cycles after DSP_A/DSP_B update. The OPMODE for each pair is
// therefore issued MLAT cycles after the pair itself.
//
// Ports:
//   CLK, RSTN            clock, asynchronous active-low reset
//   in_valid/in_ready    operand-pair handshake
//   in_a, in_b           operands (slice A / slice B), DW bits
//   in_last              pair closes the current vector
//   res_valid/res_ready  result handshake
//   res_data             completed dot product, PW bits
//   DSP_A, DSP_B         operands to the slice
//   DSP_OPMODE           slice OPMODE (X/Z multiplexer and add control)
//   DSP_CE               common clock enable to the slice, tied high
//   DSP_P                slice P output
// -----------------------------------------------------------------------------
module dsp_mac_sequencer #(
  parameter int DW   = 18,
  parameter int MLAT = 2,
  parameter int PW   = 48
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_last,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [PW-1:0] res_data,
  output logic [DW-1:0] DSP_A,
  output logic [DW-1:0] DSP_B,
  output logic [7:0]    DSP_OPMODE,
  output logic          DSP_CE,
  input  logic [PW-1:0] DSP_P
);

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_WAIT   = 1'b1
  } state_t;

  // X=M, Z=0: the first product of a vector overwrites whatever P held.
  localparam logic [7:0] OPM_FIRST = 8'b0000_0001;
  // X=M, Z=P: accumulate the product into P.
  localparam logic [7:0] OPM_ACC   = 8'b0000_1001;
  // X=0, Z=P: P holds its value through a bubble.
  localparam logic [7:0] OPM_HOLD  = 8'b0000_1000;

  state_t          r_state;
  state_t          w_nextState;
  logic            w_inReady;
  logic            w_accept;
  logic            w_resHandshake;
  logic            r_started;
  logic            r_first;
  logic [DW-1:0]   r_dspA;
  logic [DW-1:0]   r_dspB;
  logic [MLAT-1:0] r_tagV;
  logic [MLAT-1:0] r_tagFirst;
  logic [MLAT-1:0] r_tagLast;
  logic [7:0]      r_opmode;
  logic            r_opLast;
  logic            r_pLast;
  logic            r_resValid;
  logic [PW-1:0]   r_resData;

  assign w_accept       = w_inReady & in_valid;
  assign w_resHandshake = r_resValid & res_ready;

  // State register. Reset lands in ACCEPT. However, in_ready is also gated by
  // r_started, so the block does not advertise readiness while reset is held.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= ST_ACCEPT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and in_ready decode. A vector's last pair parks the sequencer
  // in WAIT. It leaves WAIT on the same edge the result is consumed. As a
  // result, in_ready returns one cycle after the result handshake.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    case (r_state)
      ST_ACCEPT: begin
        w_inReady = r_started;
        if (w_inReady && in_valid && in_last) begin
          w_nextState = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_resHandshake) begin
          w_nextState = ST_ACCEPT;
        end
      end
      default: begin
        w_nextState = ST_ACCEPT;
      end
    endcase
  end

  // Operand registers and the tag shift register. Every cycle pushes one tag.
  // A real tag marks an accepted pair. A null tag marks a bubble, so the
  // tags stay cycle-aligned with the slice's multiplier pipeline.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_started  <= 1'b0;
      r_first    <= 1'b1;
      r_dspA     <= '0;
      r_dspB     <= '0;
      r_tagV     <= '0;
      r_tagFirst <= '0;
      r_tagLast  <= '0;
    end else begin
      r_started <= 1'b1;
      if (w_accept) begin
        r_dspA  <= in_a;
        r_dspB  <= in_b;
        r_first <= in_last;
      end
      r_tagV[0]     <= w_accept;
      r_tagFirst[0] <= w_accept & r_first;
      r_tagLast[0]  <= w_accept & in_last;
      for (int i = 1; i < MLAT; i++) begin
        r_tagV[i]     <= r_tagV[i-1];
        r_tagFirst[i] <= r_tagFirst[i-1];
        r_tagLast[i]  <= r_tagLast[i-1];
      end
    end
  end

  // OPMODE is issued from the tag leaving the shift register. It therefore
  // coincides with that pair's product in the M register. The last-flag
  // takes two more register stages:
  //   - one stage alongside OPMODE,
  //   - one stage for the slice P register.
  // When the flag emerges, DSP_P already holds the finished sum, and it is
  // captured. A captured result holds until it is consumed.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_opmode   <= 8'h00;
      r_opLast   <= 1'b0;
      r_pLast    <= 1'b0;
      r_resValid <= 1'b0;
      r_resData  <= '0;
    end else begin
      if (r_tagV[MLAT-1]) begin
        r_opmode <= r_tagFirst[MLAT-1] ? OPM_FIRST : OPM_ACC;
      end else begin
        r_opmode <= OPM_HOLD;
      end
      r_opLast <= r_tagV[MLAT-1] & r_tagLast[MLAT-1];
      r_pLast  <= r_opLast;
      if (r_pLast) begin
        r_resValid <= 1'b1;
        r_resData  <= DSP_P;
      end else if (w_resHandshake) begin
        r_resValid <= 1'b0;
      end
    end
  end

  assign in_ready   = w_inReady;
  assign res_valid  = r_resValid;
  assign res_data   = r_resData;
  assign DSP_A      = r_dspA;
  assign DSP_B      = r_dspB;
  assign DSP_OPMODE = r_opmode;
  assign DSP_CE     = 1'b1;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dsp_mac_sequencer
//
// Testbench for dsp_mac_sequencer.
//   - A small behavioural slice model provides DSP_P.
//   - The expected results come from plain dot-product arithmetic.
//   - The expected OPMODE slots are derived from the cycles at which pairs
//     were accepted.
// -----------------------------------------------------------------------------
module tb_dsp_mac_sequencer;

  localparam int DW   = 18;
  localparam int MLAT = 2;
  localparam int PW   = 48;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_last;
  logic          res_valid;
  logic          res_ready;
  logic [PW-1:0] res_data;
  logic [DW-1:0] DSP_A;
  logic [DW-1:0] DSP_B;
  logic [7:0]    DSP_OPMODE;
  logic          DSP_CE;
  logic [PW-1:0] sliceP = '0;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  logic [7:0]    opLog [0:4095];
  logic [PW-1:0] mPipe [0:MLAT-1];

  dsp_mac_sequencer #(.DW(DW), .MLAT(MLAT), .PW(PW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_OPMODE(DSP_OPMODE), .DSP_CE(DSP_CE),
    .DSP_P(sliceP)
  );

  always #5 CLK = ~CLK;

  // Cycle counter: the number of rising edges seen so far.
  always @(posedge CLK) cycleCount++;

  // Record the OPMODE presented after each edge. This lets the tests compare
  // whole slot sequences once a vector has finished.
  always @(negedge CLK) opLog[cycleCount % 4096] = DSP_OPMODE;

  // Signed DW x DW product, sign-extended to the P width.
  function automatic logic [PW-1:0] product(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = $signed(a) * $signed(b);
    return {{(PW-2*DW){p[2*DW-1]}}, p};
  endfunction

  // Behavioural slice model:
  //   - The product reaches the M stage MLAT edges after DSP_A/DSP_B change.
  //   - P combines X (0 or M) with Z (0 or P) as selected by the OPMODE the
  //     sequencer presents.
  always @(posedge CLK) begin
    mPipe[0] <= product(DSP_A, DSP_B);
    for (int k = 1; k < MLAT; k++) mPipe[k] <= mPipe[k-1];
    sliceP <= ((DSP_OPMODE[3:2] == 2'b10) ? sliceP : '0) +
              ((DSP_OPMODE[1:0] == 2'b01) ? mPipe[MLAT-1] : '0);
  end

  function automatic int logIdx(input int c);
    return ((c % 4096) + 4096) % 4096;
  endfunction

  // Expected OPMODE in the slot after edge c for a vector accepted at the
  // edges listed in acc:
  //   - the first pair's slot gives 01,
  //   - every later pair's slot gives 09,
  //   - every other slot is a hold (08).
  function automatic logic [7:0] exp_opmode(input int c, input int acc[$]);
    logic [7:0] e;
    e = 8'h08;
    for (int i = 0; i < acc.size(); i++)
      if (acc[i] == c - MLAT) e = (i == 0) ? 8'h01 : 8'h09;
    return e;
  endfunction

  // Offer one pair from a falling edge until it is accepted.
  // Returns at the falling edge after the accepting rising edge.
  task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last,
                           output int accCyc, output bit timedOut);
    bit rdy;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    accCyc = -1; timedOut = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rdy = in_ready;
      @(negedge CLK);
      if (rdy) begin
        accCyc = cycleCount;
        timedOut = 1'b0;
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait at falling edges for res_valid. Stops at the first edge where it is seen.
  task automatic wait_result(input int maxCycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    RSTN = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++;
    if (res_valid !== 1'b0 || res_data !== '0) begin
      errors++; $display("[TB] FAIL reset_result got valid=%0b data=%0d exp valid=0 data=0", res_valid, res_data);
    end
    checks++;
    if (DSP_A !== '0 || DSP_B !== '0) begin
      errors++; $display("[TB] FAIL reset_operands got A=%0d B=%0d exp 0 0", DSP_A, DSP_B);
    end
    checks++;
    if (DSP_OPMODE !== 8'h00 || DSP_CE !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_opmode_ce got op=%h ce=%0b exp op=00 ce=1", DSP_OPMODE, DSP_CE);
    end
    RSTN = 1'b1;
    #1;
    checks++;
    if (DSP_OPMODE !== 8'h00) begin errors++; $display("[TB] FAIL release_opmode got=%h exp=00", DSP_OPMODE); end
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back;
    int acc[$];
    int c;
    bit to, tmo, seen;
    logic [DW-1:0] va [3] = '{18'd3, 18'd5, 18'd7};
    logic [DW-1:0] vb [3] = '{18'd4, 18'd6, 18'd8};
    logic [7:0] expOps [3] = '{8'h01, 8'h09, 8'h09};
    tmo = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send_pair(va[k], vb[k], k == 2, c, to);
      acc.push_back(c);
      tmo |= to;
    end
    checks++;
    if (tmo || acc[2] - acc[0] != 2) begin
      errors++; $display("[TB] FAIL b2b_throughput got span=%0d timeout=%0b exp span=2", acc[2] - acc[0], tmo);
      return;
    end
    wait_result(20, seen);
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL b2b_result_timeout got res_valid=0 exp 1"); return; end
    checks++;
    if (cycleCount - acc[2] != 4) begin
      errors++; $display("[TB] FAIL b2b_latency got=%0d exp=4", cycleCount - acc[2]);
    end
    checks++;
    if (res_data !== 48'd98) begin errors++; $display("[TB] FAIL b2b_data got=%0d exp=98", res_data); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_wait_ready got=%0b exp=0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (opLog[logIdx(acc[k] + MLAT)] !== expOps[k]) begin
        errors++; $display("[TB] FAIL b2b_opmode[%0d] got=%h exp=%h", k, opLog[logIdx(acc[k] + MLAT)], expOps[k]);
      end
    end
    checks++;
    if (opLog[logIdx(acc[2] + MLAT + 1)] !== 8'h08) begin
      errors++; $display("[TB] FAIL b2b_opmode_after got=%h exp=08", opLog[logIdx(acc[2] + MLAT + 1)]);
    end
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_handshake got valid=%0b ready=%0b exp valid=0 ready=1", res_valid, in_ready);
    end
  endtask

  task automatic test_single_pair;
    int c;
    bit to, seen;
    res_ready = 1'b1;
    send_pair(18'd1000, 18'd2000, 1'b1, c, to);
    wait_result(20, seen);
    checks++;
    if (to || !seen) begin
      errors++; $display("[TB] FAIL single_timeout got accept_to=%0b seen=%0b exp 0 1", to, seen);
      res_ready = 1'b0;
      return;
    end
    checks++;
    if (cycleCount - c != 4 || res_data !== 48'd2000000) begin
      errors++; $display("[TB] FAIL single_result got lat=%0d data=%0d exp lat=4 data=2000000", cycleCount - c, res_data);
    end
    @(negedge CLK);
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL single_ready_high got valid=%0b ready=%0b exp 0 1", res_valid, in_ready);
    end
    res_ready = 1'b0;
    send_pair(18'd2, 18'd2, 1'b1, c, to);
    wait_result(20, seen);
    checks++;
    if (to || !seen || res_data !== 48'd4) begin
      errors++; $display("[TB] FAIL single_no_carry got data=%0d seen=%0b exp data=4", res_data, seen);
    end
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
  endtask

  task automatic test_gaps;
    int acc[$];
    int c, bad;
    bit to, tmo, seen;
    logic [DW-1:0] va [3] = '{18'd3, 18'd5, 18'd7};
    logic [DW-1:0] vb [3] = '{18'd4, 18'd6, 18'd8};
    tmo = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send_pair(va[k], vb[k], k == 2, c, to);
      acc.push_back(c);
      tmo |= to;
      if (k < 2) repeat (2) @(negedge CLK);
    end
    wait_result(20, seen);
    checks++;
    if (tmo || !seen || res_data !== 48'd98 || cycleCount - acc[2] != 4) begin
      errors++; $display("[TB] FAIL gaps_result got data=%0d seen=%0b lat=%0d exp data=98 lat=4",
                         res_data, seen, cycleCount - acc[2]);
    end
    checks++;
    if (opLog[logIdx(acc[0] + MLAT + 1)] !== 8'h08) begin
      errors++; $display("[TB] FAIL gaps_hold_slot got=%h exp=08", opLog[logIdx(acc[0] + MLAT + 1)]);
    end
    bad = 0;
    for (int cc = acc[0] + MLAT; cc <= acc[2] + MLAT; cc++)
      if (opLog[logIdx(cc)] !== exp_opmode(cc, acc)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL gaps_opmode_seq got %0d wrong slots exp 0", bad); end
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int c;
    bit to, seen;
    int bad;
    send_pair(18'd3, 18'd4, 1'b0, c, to);
    send_pair(18'd5, 18'd6, 1'b0, c, to);
    send_pair(18'd7, 18'd8, 1'b1, c, to);
    wait_result(20, seen);
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL hold_timeout got res_valid=0 exp 1"); return; end
    in_valid = 1'b1; in_a = 18'd999; in_b = 18'd1; in_last = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 48'd98 || in_ready !== 1'b0 || DSP_A !== 18'd7) begin
        errors++; bad++;
        $display("[TB] FAIL hold_cycle%0d got valid=%0b data=%0d ready=%0b A=%0d exp 1 98 0 7",
                 k, res_valid, res_data, in_ready, DSP_A);
      end
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL hold_release got valid=%0b ready=%0b exp 0 1", res_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_vector;
    int c;
    bit to, seen, sawValid;
    send_pair(18'd3, 18'd4, 1'b0, c, to);
    send_pair(18'd5, 18'd6, 1'b0, c, to);
    RSTN = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || DSP_OPMODE !== 8'h00 || DSP_A !== '0 || res_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_state got ready=%0b op=%h A=%0d valid=%0b exp 0 00 0 0",
                         in_ready, DSP_OPMODE, DSP_A, res_valid);
    end
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    sawValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (res_valid) sawValid = 1'b1;
    end
    checks++;
    if (sawValid) begin errors++; $display("[TB] FAIL midreset_no_result got res_valid=1 exp 0"); end
    send_pair(18'd1, 18'd1, 1'b1, c, to);
    wait_result(20, seen);
    checks++;
    if (to || !seen || res_data !== 48'd1) begin
      errors++; $display("[TB] FAIL midreset_next got data=%0d seen=%0b exp data=1", res_data, seen);
    end
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
  endtask

  task automatic test_random;
    for (int v = 0; v < 25; v++) begin
      int acc[$];
      int len, c, bad, dly;
      bit to, tmo, seen;
      longint sum;
      logic [PW-1:0] expData;
      logic [31:0] ra, rb;
      len = $urandom_range(1, 6);
      sum = 0; tmo = 1'b0;
      for (int k = 0; k < len; k++) begin
        ra = $urandom; rb = $urandom;
        sum += longint'($signed(ra[DW-1:0])) * longint'($signed(rb[DW-1:0]));
        send_pair(ra[DW-1:0], rb[DW-1:0], k == len - 1, c, to);
        acc.push_back(c);
        tmo |= to;
        if (k < len - 1) repeat ($urandom_range(0, 2)) @(negedge CLK);
      end
      expData = sum[PW-1:0];
      wait_result(20, seen);
      checks++;
      if (tmo || !seen || res_data !== expData || cycleCount - acc[len-1] != 4) begin
        errors++; $display("[TB] FAIL rand_vec%0d got data=%h seen=%0b lat=%0d exp data=%h lat=4",
                           v, res_data, seen, cycleCount - acc[len-1], expData);
      end
      bad = 0;
      for (int cc = acc[0] + MLAT; cc <= acc[len-1] + MLAT; cc++)
        if (opLog[logIdx(cc)] !== exp_opmode(cc, acc)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("[TB] FAIL rand_opmode%0d got %0d wrong slots exp 0", v, bad); end
      dly = $urandom_range(0, 3);
      repeat (dly) @(negedge CLK);
      res_ready = 1'b1;
      @(negedge CLK);
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL rand_handshake%0d got valid=%0b ready=%0b exp 0 1", v, res_valid, in_ready);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting dsp_mac_sequencer tests");
    test_reset();
    test_back_to_back();
    test_single_pair();
    test_gaps();
    test_backpressure();
    test_reset_mid_vector();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
